rim_job_scheduler: RTL and testbench

- Shares one rat-in-maze solver between N_REQ maze sources.
- Arbitrates round-robin and streams the winner's 8 maze rows into the solver (in_valid/maze interface).
- Waits for the 15-beat coordinate answer, bounded by a timeout, and returns it tagged with the requester id.
- Sits between the maze producers and the solver. The solver has no reset-on-demand, no fail flag and no backpressure, so this block owns all sequencing.

---
 rtl/rim_job_scheduler.sv | 173 +++++++++++++++++
 tb/tb_rim_job_scheduler.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/rim_job_scheduler.sv
// Round-robin front end for a single rat-in-maze solver: grants one requester,
// streams its 8 maze rows in, then collects the 15-beat answer or times out.
module rim_job_scheduler #(
   parameter  int N_REQ   = 2,
   parameter  int TIMEOUT = 255,
   parameter  int GAP     = 1,
   localparam int ID_W    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [N_REQ-1:0]   req,
   input  logic [8*N_REQ-1:0] req_maze,
   output logic [N_REQ-1:0]   gnt,
   output logic               slv_in_valid,
   output logic [7:0]         slv_maze,
   input  logic               slv_out_valid,
   input  logic [2:0]         slv_out_row,
   input  logic [2:0]         slv_out_col,
   output logic               res_valid,
   output logic [ID_W-1:0]    res_id,
   output logic [2:0]         res_row,
   output logic [2:0]         res_col,
   output logic               res_last,
   output logic               res_timeout,
   output logic               busy
);

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SOLVE, S_DRAIN, S_GAP} state_t;

   state_t            r_state;
   logic [ID_W-1:0]   r_rr;
   logic [ID_W-1:0]   r_job_id;
   logic [N_REQ-1:0]  r_gnt;
   logic [2:0]        r_row;
   logic [11:0]       r_tcnt;
   logic [3:0]        r_beat;
   logic [2:0]        r_gcnt;
   logic              r_slv_vld;
   logic [7:0]        r_slv_maze;
   logic              r_res_valid;
   logic [ID_W-1:0]   r_res_id;
   logic [2:0]        r_res_row;
   logic [2:0]        r_res_col;
   logic              r_res_last;
   logic              r_res_timeout;

   logic              w_any;
   logic [ID_W-1:0]   w_win;
   logic [ID_W-1:0]   w_idx;
   logic [N_REQ-1:0]  w_onehot;
   logic [ID_W-1:0]   w_rr_next;

   // First requester at or after the rr pointer, wrapping.
   always_comb begin
      w_any    = 1'b0;
      w_win    = '0;
      w_idx    = '0;
      w_onehot = '0;
      for (int k = 0; k < N_REQ; k++) begin
         w_idx = ID_W'((int'(r_rr) + k) % N_REQ);
         if (!w_any && req[w_idx]) begin
            w_any = 1'b1;
            w_win = w_idx;
         end
      end
      w_onehot[w_win] = 1'b1;
   end

   assign w_rr_next = (w_win == ID_W'(N_REQ - 1)) ? '0 : w_win + ID_W'(1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= S_IDLE;
         r_rr          <= '0;
         r_job_id      <= '0;
         r_gnt         <= '0;
         r_row         <= '0;
         r_tcnt        <= '0;
         r_beat        <= '0;
         r_gcnt        <= '0;
         r_slv_vld     <= 1'b0;
         r_slv_maze    <= '0;
         r_res_valid   <= 1'b0;
         r_res_id      <= '0;
         r_res_row     <= '0;
         r_res_col     <= '0;
         r_res_last    <= 1'b0;
         r_res_timeout <= 1'b0;
      end else begin
         // Result and solver-input registers are single-cycle pulses by default.
         r_res_valid   <= 1'b0;
         r_res_id      <= '0;
         r_res_row     <= '0;
         r_res_col     <= '0;
         r_res_last    <= 1'b0;
         r_res_timeout <= 1'b0;
         r_slv_vld     <= 1'b0;
         r_slv_maze    <= '0;
         case (r_state)
            S_IDLE: begin
               if (w_any) begin
                  r_job_id <= w_win;
                  r_gnt    <= w_onehot;
                  r_rr     <= w_rr_next;
                  r_row    <= '0;
                  r_state  <= S_LOAD;
               end
            end
            S_LOAD: begin
               r_slv_vld  <= 1'b1;
               r_slv_maze <= req_maze[{r_job_id, 3'b000} +: 8];
               r_row      <= r_row + 3'd1;
               if (r_row == 3'd7) begin
                  r_gnt   <= '0;
                  r_tcnt  <= '0;
                  r_state <= S_SOLVE;
               end
            end
            S_SOLVE: begin
               // A valid beat on the timeout cycle still counts as an answer.
               if (slv_out_valid) begin
                  r_res_valid <= 1'b1;
                  r_res_id    <= r_job_id;
                  r_res_row   <= slv_out_row;
                  r_res_col   <= slv_out_col;
                  r_beat      <= 4'd1;
                  r_state     <= S_DRAIN;
               end else if (r_tcnt == 12'(TIMEOUT)) begin
                  r_res_valid   <= 1'b1;
                  r_res_id      <= r_job_id;
                  r_res_last    <= 1'b1;
                  r_res_timeout <= 1'b1;
                  r_gcnt        <= '0;
                  r_state       <= S_GAP;
               end else if (r_tcnt != 12'hFFF) begin
                  r_tcnt <= r_tcnt + 12'd1;
               end
            end
            S_DRAIN: begin
               if (slv_out_valid) begin
                  r_res_valid <= 1'b1;
                  r_res_id    <= r_job_id;
                  r_res_row   <= slv_out_row;
                  r_res_col   <= slv_out_col;
                  r_beat      <= r_beat + 4'd1;
                  if (r_beat == 4'd14) begin
                     r_res_last <= 1'b1;
                     r_gcnt     <= '0;
                     r_state    <= S_GAP;
                  end
               end
            end
            S_GAP: begin
               if (r_gcnt == 3'(GAP - 1)) r_state <= S_IDLE;
               else                       r_gcnt  <= r_gcnt + 3'd1;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign gnt          = r_gnt;
   assign slv_in_valid = r_slv_vld;
   assign slv_maze     = r_slv_maze;
   assign res_valid    = r_res_valid;
   assign res_id       = r_res_id;
   assign res_row      = r_res_row;
   assign res_col      = r_res_col;
   assign res_last     = r_res_last;
   assign res_timeout  = r_res_timeout;
   assign busy         = (r_state != S_IDLE);

endmodule

// File: tb/tb_rim_job_scheduler.sv
// Directed bench for rim_job_scheduler: load, drain, contention, timeout,
// stray solver output, gapped drain and reset in the middle of a load.
module tb_rim_job_scheduler;

   localparam int N_REQ = 2;
   localparam int TMO   = 10;
   localparam int GAPC  = 2;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [1:0]  req;
   logic [15:0] req_maze;
   logic [1:0]  gnt;
   logic        slv_in_valid;
   logic [7:0]  slv_maze;
   logic        slv_out_valid;
   logic [2:0]  slv_out_row;
   logic [2:0]  slv_out_col;
   logic        res_valid;
   logic [0:0]  res_id;
   logic [2:0]  res_row;
   logic [2:0]  res_col;
   logic        res_last;
   logic        res_timeout;
   logic        busy;

   int total = 0;
   int bad   = 0;

   rim_job_scheduler #(.N_REQ(N_REQ), .TIMEOUT(TMO), .GAP(GAPC)) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .req_maze(req_maze), .gnt(gnt),
      .slv_in_valid(slv_in_valid), .slv_maze(slv_maze),
      .slv_out_valid(slv_out_valid), .slv_out_row(slv_out_row), .slv_out_col(slv_out_col),
      .res_valid(res_valid), .res_id(res_id), .res_row(res_row), .res_col(res_col),
      .res_last(res_last), .res_timeout(res_timeout), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] rv(input logic [7:0] base, input logic [7:0] stp, input int k);
      return base + 8'(int'(stp) * k);
   endfunction

   task automatic set_lanes(input int id, input logic [7:0] r);
      req_maze = (id == 0) ? {~r, r} : {r, ~r};
   endtask

   // Entered in IDLE with req already driven; leaves on SOLVE cycle 0.
   task automatic do_load(input int id, input logic [7:0] base, input logic [7:0] stp,
                          input logic [1:0] req_after);
      step();
      req = req_after;
      for (int k = 0; k < 8; k++) begin
         check("load_gnt", 32'(gnt), 32'(2'(32'd1 << id)));
         if (k > 0)
            check("load_row", 32'({slv_in_valid, slv_maze}), 32'({1'b1, rv(base, stp, k - 1)}));
         else
            check("load_first", 32'({slv_in_valid, busy}), 32'(2'b01));
         set_lanes(id, rv(base, stp, k));
         step();
      end
      check("solve_entry", 32'({gnt, slv_in_valid, slv_maze, busy}),
            32'({2'b00, 1'b1, rv(base, stp, 7), 1'b1}));
   endtask

   // From the cycle after the final result beat: GAPC busy cycles, then IDLE.
   task automatic gap_tail();
      check("gap_busy0", 32'(busy), 32'd1);
      step();
      check("gap_busy1", 32'({busy, res_valid, gnt}), 32'({1'b1, 1'b0, 2'b00}));
      step();
      check("gap_idle", 32'({busy, gnt}), 32'd0);
   endtask

   // Solver model: silent for lat SOLVE cycles, then 15 beats (optional 3-cycle hole after beat 7).
   task automatic drain(input int id, input int lat, input bit gapped);
      slv_out_valid = 1'b0;
      for (int j = 0; j < lat; j++) begin
         step();
         check("solve_wait", 32'({res_valid, busy, slv_in_valid}), 32'(3'b010));
      end
      for (int b = 0; b < 15; b++) begin
         slv_out_valid = 1'b1;
         slv_out_row   = 3'(b);
         slv_out_col   = 3'(14 - b);
         step();
         check("beat", 32'({res_valid, res_id, res_row, res_col, res_last, res_timeout}),
               32'({1'b1, 1'(id), 3'(b), 3'(14 - b), (b == 14), 1'b0}));
         if (gapped && b == 7) begin
            slv_out_valid = 1'b0;
            for (int h = 0; h < 3; h++) begin
               step();
               check("drain_hole", 32'({res_valid, busy}), 32'(2'b01));
            end
         end
      end
      slv_out_valid = 1'b0;
      slv_out_row   = '0;
      slv_out_col   = '0;
      gap_tail();
   endtask

   initial begin
      rst_n = 1'b0;
      req = '0;
      req_maze = '0;
      slv_out_valid = 1'b0;
      slv_out_row = '0;
      slv_out_col = '0;

      // Reset state
      step();
      step();
      check("reset_outs", 32'({gnt, slv_in_valid, slv_maze, res_valid, res_id, res_row,
                              res_col, res_last, res_timeout, busy}), 32'd0);
      rst_n = 1'b1;
      step();
      check("idle_no_req", 32'({gnt, busy}), 32'd0);

      // Single job, all-open maze
      req = 2'b01;
      do_load(0, 8'hFF, 8'h00, 2'b00);
      drain(0, 4, 1'b0);

      // Reset during LOAD after 4 rows
      req = 2'b01;
      step();
      req = 2'b00;
      for (int k = 0; k < 4; k++) begin
         set_lanes(0, rv(8'h31, 8'h07, k));
         step();
      end
      check("pre_reset_load", 32'({gnt, slv_in_valid, slv_maze, busy}),
            32'({2'b01, 1'b1, rv(8'h31, 8'h07, 3), 1'b1}));
      rst_n = 1'b0;
      #1;
      check("mid_load_reset", 32'({gnt, slv_in_valid, busy}), 32'd0);
      step();
      rst_n = 1'b1;
      req = 2'b10;
      do_load(1, 8'h5A, 8'h13, 2'b00);
      drain(1, 5, 1'b0);

      // Contention: req held high for four jobs
      req = 2'b11;
      do_load(0, 8'h12, 8'h23, 2'b11);
      drain(0, 3, 1'b0);
      do_load(1, 8'h81, 8'h05, 2'b11);
      drain(1, 3, 1'b0);
      do_load(0, 8'h40, 8'h11, 2'b11);
      drain(0, 3, 1'b0);
      do_load(1, 8'hC3, 8'h09, 2'b00);
      drain(1, 3, 1'b0);

      // Timeout: solver silent; decision on SOLVE cycle TMO, beat visible one cycle later
      req = 2'b01;
      do_load(0, 8'h0F, 8'h21, 2'b00);
      for (int j = 1; j <= TMO; j++) begin
         step();
         check("tmo_wait", 32'({res_valid, busy}), 32'(2'b01));
      end
      step();
      check("tmo_beat", 32'({res_valid, res_id, res_row, res_col, res_last, res_timeout}),
            32'({1'b1, 1'b0, 3'd0, 3'd0, 1'b1, 1'b1}));
      gap_tail();

      // Stray solver output while idle
      for (int b = 0; b < 15; b++) begin
         slv_out_valid = 1'b1;
         slv_out_row   = 3'(b);
         slv_out_col   = 3'(b + 1);
         step();
         check("stray", 32'({res_valid, busy, gnt}), 32'd0);
      end
      slv_out_valid = 1'b0;

      // Valid arrives exactly on the timeout cycle: normal result
      req = 2'b10;
      do_load(1, 8'h66, 8'h0B, 2'b00);
      drain(1, TMO, 1'b0);

      // Gapped drain
      req = 2'b01;
      do_load(0, 8'hA5, 8'h1D, 2'b00);
      drain(0, 2, 1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
